// File: rtl/filter_pkg.sv
// Shared window geometry for the filter path: pixel/window widths and the
// packed bit offset of a window element.
package filter_pkg;

  localparam int unsigned PIXEL_W  = 8;
  localparam int unsigned WIN_DIM  = 3;
  localparam int unsigned WINDOW_W = PIXEL_W * WIN_DIM * WIN_DIM;

  typedef logic [PIXEL_W-1:0]  pixel_t;
  typedef logic [WINDOW_W-1:0] window_t;

  // Element (r, c) of a window; r=0 is the oldest row, c=0 the leftmost column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return PIXEL_W * (WIN_DIM * r + c);
  endfunction

endpackage

// File: rtl/window_3x3_gen_if.sv
// Pixel-in / window-out stream bundle between a pixel source, the window
// generator and a window-consuming filter.
interface window_3x3_gen_if;
  import filter_pkg::*;

  logic    in_valid;
  logic    in_ready;
  pixel_t  in_data;
  logic    out_valid;
  logic    out_ready;
  window_t out_window;
  logic    out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_window, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_window, out_last
  );

endinterface

// File: rtl/window_3x3_gen_line_buffer.sv
// One image row of pixels: combinational read and synchronous write at the
// same address. Contents are deliberately not reset.
module line_buffer #(
  parameter  int unsigned DEPTH = 256,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: raster pixels in, one packed window
// out per interior pixel, single flow-controlled output register.
module window_3x3_gen
  import filter_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 256,
  parameter int unsigned IMG_HEIGHT = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  window_3x3_gen_if.slave  bus
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(2);
  localparam logic [RW-1:0] ROW_MIN  = RW'(2);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  window_t       win_q, win_d;
  window_t       shifted;
  window_t       owin_q, owin_d;
  logic          ovalid_q, ovalid_d;
  logic          olast_q, olast_d;
  pixel_t        top_rd, mid_rd;
  logic          ready, accept, interior;

  assign ready    = !ovalid_q || bus.out_ready;
  assign accept   = bus.in_valid && ready;
  assign interior = (row_q >= ROW_MIN) && (col_q >= COL_MIN);

  // Accepting a pixel ages column c down one line: mid row moves to top,
  // the new pixel becomes the mid row.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb_top (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (mid_rd),
    .rdata_o (top_rd)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIXEL_W)) u_lb_mid (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (col_q),
    .wdata_i (bus.in_data),
    .rdata_o (mid_rd)
  );

  always_comb begin
    shifted = '0;
    for (int unsigned r = 0; r < WIN_DIM; r++) begin
      for (int unsigned c = 0; c < WIN_DIM - 1; c++) begin
        shifted[win_idx(r, c) +: PIXEL_W] = win_q[win_idx(r, c + 1) +: PIXEL_W];
      end
    end
    shifted[win_idx(0, 2) +: PIXEL_W] = top_rd;
    shifted[win_idx(1, 2) +: PIXEL_W] = mid_rd;
    shifted[win_idx(2, 2) +: PIXEL_W] = bus.in_data;
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    win_d    = win_q;
    owin_d   = owin_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;

    if (accept) begin
      win_d = shifted;
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A new interior window takes priority over draining the current one.
    if (accept && interior) begin
      owin_d   = shifted;
      ovalid_d = 1'b1;
      olast_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
    end else if (ovalid_q && bus.out_ready) begin
      ovalid_d = 1'b0;
      olast_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      win_q    <= '0;
      owin_q   <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      win_q    <= win_d;
      owin_q   <= owin_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = ovalid_q;
  assign bus.out_window = owin_q;
  assign bus.out_last   = olast_q;

endmodule
